pc_btb_unit: RTL and testbench

PC_BTB_UNIT -- requirements
Module: pc_btb_unit

---
 rtl/pc_btb_unit.sv | 193 +++++++++++++++++++
 tb/tb_pc_btb_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_btb_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_btb_unit
// Description : Fetch PC register with an optional direct-mapped branch
//               target buffer (BTB). Each entry holds valid, tag, target and
//               a 2-bit saturating direction counter. Execute-stage branch,
//               JAL and JALR outcomes train the table and raise mispredictE
//               when the carried-down prediction was wrong.
//
//               Build macro PC_BTB_PREDICT_EN: when defined, the BTB and
//               the prediction path are compiled in. When undefined, no
//               table exists, fetch always predicts not-taken (pcF+4) and
//               every taken control transfer redirects.
//
// Parameters  : DATA_WIDTH  - PC / target width in bits
//               BTB_ENTRIES - number of entries, power of two in 2..256
//               RESET_PC    - PC loaded while rst is low
//
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous active-low reset
//               en           - fetch enable (0 stalls pcF)
//               ctrlE        - valid branch/JAL/JALR in Execute
//               branchE      - branch/JAL in Execute resolved taken
//               jalrinsE     - JALR in Execute
//               pcE          - PC of Execute instruction
//               pc_targetE   - branch/JAL target
//               alu_outE     - raw JALR target (bit 0 is cleared)
//               predtakenE   - prediction carried with Execute instruction
//               predtargetE  - predicted target carried with it
//               pcF          - fetch PC
//               pc_plus4F    - pcF + 4
//               predtakenF   - fetch predicted taken
//               predtargetF  - fetch predicted next PC
//               mispredictE  - flush request for F/D and D/E
//
// Revision    : 1.0 - initial release
// ============================================================================
module pc_btb_unit #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    BTB_ENTRIES = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ctrlE,
  input  logic                  branchE,
  input  logic                  jalrinsE,
  input  logic [DATA_WIDTH-1:0] pcE,
  input  logic [DATA_WIDTH-1:0] pc_targetE,
  input  logic [DATA_WIDTH-1:0] alu_outE,
  input  logic                  predtakenE,
  input  logic [DATA_WIDTH-1:0] predtargetE,
  output logic [DATA_WIDTH-1:0] pcF,
  output logic [DATA_WIDTH-1:0] pc_plus4F,
  output logic                  predtakenF,
  output logic [DATA_WIDTH-1:0] predtargetF,
  output logic                  mispredictE
);

  localparam logic [DATA_WIDTH-1:0] c_pc_step = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_actual_target;
  logic                  w_actual_taken;
  logic                  w_mispredict;

  // Arithmetic is naturally modulo 2^DATA_WIDTH.
  assign w_pc_plus4      = r_pc + c_pc_step;
  // JALR targets are halfword-aligned: force bit 0 low.
  assign w_actual_target = jalrinsE ? {alu_outE[DATA_WIDTH-1:1], 1'b0} : pc_targetE;
  assign w_actual_taken  = branchE | jalrinsE;

  assign pcF         = r_pc;
  assign pc_plus4F   = w_pc_plus4;
  assign mispredictE = w_mispredict;

`ifdef PC_BTB_PREDICT_EN

  localparam int c_idx_w = $clog2(BTB_ENTRIES);
  localparam int c_tag_w = DATA_WIDTH - c_idx_w - 2;

  logic                  r_valid  [BTB_ENTRIES];
  logic [c_tag_w-1:0]    r_tag    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0] r_target [BTB_ENTRIES];
  logic [1:0]            r_ctr    [BTB_ENTRIES];

  logic [c_idx_w-1:0]    w_f_idx;
  logic [c_tag_w-1:0]    w_f_tag;
  logic [c_idx_w-1:0]    w_e_idx;
  logic [c_tag_w-1:0]    w_e_tag;
  logic                  w_f_hit;
  logic                  w_e_hit;
  logic                  w_predtaken;
  logic                  w_unused;

  assign w_f_idx = r_pc[c_idx_w+1:2];
  assign w_f_tag = r_pc[DATA_WIDTH-1:c_idx_w+2];
  assign w_e_idx = pcE[c_idx_w+1:2];
  assign w_e_tag = pcE[DATA_WIDTH-1:c_idx_w+2];

  // Lookup reads registered table state only, so a same-cycle write to the
  // same index is seen on the following cycle.
  assign w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_e_hit     = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
  assign w_predtaken = w_f_hit && r_ctr[w_f_idx][1];

  assign predtakenF  = w_predtaken;
  assign predtargetF = w_predtaken ? r_target[w_f_idx] : w_pc_plus4;

  // Wrong if taken but predicted not-taken or to another target, or if
  // predicted taken but fell through.
  assign w_mispredict = ctrlE & (w_actual_taken
                                 ? (!predtakenE || (predtargetE != w_actual_target))
                                 : predtakenE);

  always_comb begin
    w_pc_next = r_pc;
    if (w_mispredict) begin
      w_pc_next = w_actual_taken ? w_actual_target : (pcE + c_pc_step);
    end else if (en) begin
      w_pc_next = predtargetF;
    end
  end

  // Table training is independent of the fetch enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (ctrlE) begin
      if (w_actual_taken) begin
        if (w_e_hit) begin
          r_target[w_e_idx] <= w_actual_target;
          if (r_ctr[w_e_idx] != 2'b11) begin
            r_ctr[w_e_idx] <= r_ctr[w_e_idx] + 2'b01;
          end
        end else begin
          // Allocate as weak-taken, replacing whatever lived at this index.
          r_valid[w_e_idx]  <= 1'b1;
          r_tag[w_e_idx]    <= w_e_tag;
          r_target[w_e_idx] <= w_actual_target;
          r_ctr[w_e_idx]    <= 2'b10;
        end
      end else if (w_e_hit) begin
        if (r_ctr[w_e_idx] != 2'b00) begin
          r_ctr[w_e_idx] <= r_ctr[w_e_idx] - 2'b01;
        end
      end
    end
  end

  assign w_unused = alu_outE[0];

`else

  logic w_unused;

  assign predtakenF  = 1'b0;
  assign predtargetF = w_pc_plus4;

  // Fetch always falls through, so only taken transfers are wrong.
  assign w_mispredict = ctrlE & w_actual_taken;

  always_comb begin
    w_pc_next = r_pc;
    if (w_mispredict) begin
      w_pc_next = w_actual_target;
    end else if (en) begin
      w_pc_next = w_pc_plus4;
    end
  end

  assign w_unused = ^{alu_outE[0], pcE, predtakenE, predtargetE};

`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_btb_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_btb_unit
// Description : Directed self-checking bench for pc_btb_unit (default
//               parameters: 32-bit PC, 16 entries, RESET_PC = 0). Expected
//               values follow the build: with PC_BTB_PREDICT_EN defined the
//               BTB predictions apply, otherwise fetch always falls through.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_btb_unit;

`ifdef PC_BTB_PREDICT_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic        ctrlE;
  logic        branchE;
  logic        jalrinsE;
  logic [31:0] pcE;
  logic [31:0] pc_targetE;
  logic [31:0] alu_outE;
  logic        predtakenE;
  logic [31:0] predtargetE;
  logic [31:0] pcF;
  logic [31:0] pc_plus4F;
  logic        predtakenF;
  logic [31:0] predtargetF;
  logic        mispredictE;

  int n_checks = 0;
  int n_fail   = 0;

  pc_btb_unit dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ctrlE       (ctrlE),
    .branchE     (branchE),
    .jalrinsE    (jalrinsE),
    .pcE         (pcE),
    .pc_targetE  (pc_targetE),
    .alu_outE    (alu_outE),
    .predtakenE  (predtakenE),
    .predtargetE (predtargetE),
    .pcF         (pcF),
    .pc_plus4F   (pc_plus4F),
    .predtakenF  (predtakenF),
    .predtargetF (predtargetF),
    .mispredictE (mispredictE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ctrlE      = 1'b0;
    branchE    = 1'b0;
    jalrinsE   = 1'b0;
    predtakenE = 1'b0;
  endtask

  task automatic ctl(input logic br, input logic jr, input logic [31:0] pe,
                     input logic [31:0] tg, input logic [31:0] alu,
                     input logic ptk, input logic [31:0] ptg);
    ctrlE       = 1'b1;
    branchE     = br;
    jalrinsE    = jr;
    pcE         = pe;
    pc_targetE  = tg;
    alu_outE    = alu;
    predtakenE  = ptk;
    predtargetE = ptg;
  endtask

  // Redirect fetch to an arbitrary PC with a mispredicted JAL from 0x80.
  task automatic jump_to(input logic [31:0] dst);
    ctl(1'b1, 1'b0, 32'h80, dst, 32'h0, 1'b0, 32'h0);
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b0; en = 1'b1;
    pcE = '0; pc_targetE = '0; alu_outE = '0; predtargetE = '0;
    idle();

    // Reset state
    #2;
    chk("rst_pcF", pcF, 32'h0);
    chk("rst_plus4", pc_plus4F, 32'h4);
    chk("rst_predtaken", 32'(predtakenF), 32'h0);
    chk("rst_predtarget", predtargetF, 32'h4);
    @(posedge clk);
    #6 rst = 1'b1;
    #1 chk("first_fetch", pcF, 32'h0);

    // Sequential fetch
    tick(); chk("seq_4", pcF, 32'h4); chk("seq_pt", 32'(predtakenF), 32'h0);
    tick(); chk("seq_8", pcF, 32'h8);
    tick(); chk("seq_c", pcF, 32'hC);

    // Taken branch 0x10 -> 0x40, not predicted
    ctl(1'b1, 1'b0, 32'h10, 32'h40, 32'h0, 1'b0, 32'h0);
    #1 chk("br_mispred", 32'(mispredictE), 32'h1);
    tick(); chk("br_redirect", pcF, 32'h40);
    idle();
    jump_to(32'h10);
    chk("br_pcF_10", pcF, 32'h10);
    chk("br_predtaken", 32'(predtakenF), P ? 32'h1 : 32'h0);
    chk("br_predtarget", predtargetF, P ? 32'h40 : 32'h14);
    tick(); chk("br_follow", pcF, P ? 32'h40 : 32'h14);

    // Aliasing: 0x50 shares index 4 with 0x10
    jump_to(32'h50);
    chk("alias_miss", 32'(predtakenF), 32'h0);
    chk("alias_miss_tgt", predtargetF, 32'h54);
    ctl(1'b1, 1'b0, 32'h50, 32'h90, 32'h0, 1'b0, 32'h0);
    tick(); chk("alias_redirect", pcF, 32'h90);
    idle();
    jump_to(32'h50);
    chk("alias_hit", 32'(predtakenF), P ? 32'h1 : 32'h0);
    chk("alias_hit_tgt", predtargetF, P ? 32'h90 : 32'h54);
    jump_to(32'h10);
    chk("alias_evicted", 32'(predtakenF), 32'h0);
    chk("alias_evict_tgt", predtargetF, 32'h14);

    // Re-allocate 0x10, then resolve it not-taken twice
    ctl(1'b1, 1'b0, 32'h10, 32'h40, 32'h0, 1'b0, 32'h0);
    tick(); chk("realloc", pcF, 32'h40);
    ctl(1'b0, 1'b0, 32'h10, 32'h40, 32'h0, 1'b1, 32'h40);
    #1 chk("nt1_mispred", 32'(mispredictE), P ? 32'h1 : 32'h0);
    tick(); chk("nt1_pcF", pcF, P ? 32'h14 : 32'h44);
    en = 1'b0;
    ctl(1'b0, 1'b0, 32'h10, 32'h40, 32'h0, 1'b0, 32'h40);
    #1 chk("nt2_mispred", 32'(mispredictE), 32'h0);
    tick(); chk("nt2_hold", pcF, P ? 32'h14 : 32'h44);
    en = 1'b1;
    idle();
    jump_to(32'h10);
    chk("nt_predtaken", 32'(predtakenF), 32'h0);
    chk("nt_predtarget", predtargetF, 32'h14);

    // Correctly predicted taken outcomes step the counter 00 -> 01 -> 10;
    // a same-cycle update must not affect the current lookup.
    en = 1'b0;
    ctl(1'b1, 1'b0, 32'h10, 32'h40, 32'h0, 1'b1, 32'h40);
    tick(); chk("inc1_predtaken", 32'(predtakenF), 32'h0);
    chk("inc1_pcF", pcF, P ? 32'h10 : 32'h40);
    #1 chk("inc2_sameclk", 32'(predtakenF), 32'h0);
    tick(); chk("inc2_predtaken", 32'(predtakenF), P ? 32'h1 : 32'h0);
    chk("inc2_predtarget", predtargetF, P ? 32'h40 : 32'h44);
    en = 1'b1;
    idle();

    // JALR: bit 0 of the raw target is cleared
    ctl(1'b0, 1'b1, 32'h20, 32'h999, 32'h101, 1'b0, 32'h0);
    #1 chk("jalr1_mispred", 32'(mispredictE), 32'h1);
    tick(); chk("jalr1_pcF", pcF, 32'h100);
    ctl(1'b0, 1'b1, 32'h20, 32'h999, 32'h201, 1'b1, 32'h100);
    #1 chk("jalr2_mispred", 32'(mispredictE), 32'h1);
    tick(); chk("jalr2_pcF", pcF, 32'h200);
    en = 1'b0;
    ctl(1'b0, 1'b1, 32'h20, 32'h999, 32'h200, 1'b1, 32'h200);
    #1 chk("jalr3_mispred", 32'(mispredictE), P ? 32'h0 : 32'h1);
    tick(); chk("jalr3_pcF", pcF, 32'h200);

    // en=0: redirect still applies, otherwise pcF holds
    ctl(1'b1, 1'b0, 32'h30, 32'h300, 32'h0, 1'b0, 32'h0);
    tick(); chk("stall_redirect", pcF, 32'h300);
    idle();
    tick(); chk("stall_hold", pcF, 32'h300);
    en = 1'b1;
    jump_to(32'h30);
    chk("pre_rst_pred", 32'(predtakenF), P ? 32'h1 : 32'h0);

    // Reset mid-run overrides a pending redirect and clears the table
    ctl(1'b1, 1'b0, 32'h30, 32'h300, 32'h0, 1'b0, 32'h0);
    #1 rst = 1'b0;
    #1 chk("midrst_pcF", pcF, 32'h0);
    chk("midrst_predtaken", 32'(predtakenF), 32'h0);
    chk("midrst_predtarget", predtargetF, 32'h4);
    tick(); chk("midrst_edge", pcF, 32'h0);
    idle();
    rst = 1'b1;
    #1 chk("midrst_release", pcF, 32'h0);
    jump_to(32'h30);
    chk("post_rst_pred", 32'(predtakenF), 32'h0);
    chk("post_rst_tgt", predtargetF, 32'h34);

    // Wrap-around
    jump_to(32'hFFFF_FFFC);
    chk("wrap_pcF", pcF, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4F, 32'h0);
    tick(); chk("wrap_next", pcF, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
